// File: rtl/alu_complete.sv
// ============================================================================
// Module   : alu_complete
// Brief    : 32-bit MIPS-style execute-stage ALU with ALU-control decode,
//            registered result and zero flag. Optional SLT/NOR via ALU_SLT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_complete #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       funct,
    input  logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_res,
    output logic             zero
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;

    localparam logic [5:0] FN_MULT = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
`ifdef ALU_SLT_EN
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
`endif

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] prod;
    logic signed [WIDTH-1:0] quot;
    logic signed [WIDTH-1:0] safe_div;
    logic        [WIDTH-1:0] result;

    // Divisor forced non-zero so the divider never sees 0; the B==0 and
    // MIN/-1 cases are overridden explicitly below.
    assign safe_div = (B == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : $signed(B);
    assign prod     = $signed(A) * $signed(B);
    assign quot     = $signed(A) / safe_div;

    always_comb begin
        result = '0;
        case (alu_op)
            OP_SUB:   result = A - B;
            OP_RTYPE: begin
                case (funct)
                    FN_MULT: result = prod;
                    FN_DIV: begin
                        if (B == '0)
                            result = ALL_ONES;
                        else if (A == MIN_NEG && B == ALL_ONES)
                            result = MIN_NEG;
                        else
                            result = quot;
                    end
                    FN_ADD:  result = A + B;
                    FN_SUB:  result = A - B;
                    FN_AND:  result = A & B;
                    FN_OR:   result = A | B;
`ifdef ALU_SLT_EN
                    FN_NOR:  result = ~(A | B);
                    FN_SLT:  result = ($signed(A) < $signed(B)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
`endif
                    default: result = '0;
                endcase
            end
            OP_ADD:   result = A + B;
            default:  result = A + B;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res <= '0;
            zero    <= 1'b1;
        end else begin
            alu_res <= result;
            zero    <= (result == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_complete.sv
// ============================================================================
// Module   : tb_alu_complete
// Brief    : Self-checking bench for alu_complete (directed table, reset
//            sequences, randomized stimulus against a 64-bit arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_complete;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  funct;
    logic [1:0]  alu_op;
    logic [31:0] alu_res;
    logic        zero;

    int errors;
    int checks;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic [1:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    alu_complete #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .funct   (funct),
        .alu_op  (alu_op),
        .alu_res (alu_res),
        .zero    (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model from the arithmetic rules, using 64-bit signed math.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f, input logic [1:0] op);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = 0;
        if (op == 2'd1) r = sa - sb;
        else if (op != 2'd2) r = sa + sb;
        else begin
            case (f)
                6'h18: r = sa * sb;
                6'h1A: r = (sb == 0) ? -1 : sa / sb;
                6'h20: r = sa + sb;
                6'h22: r = sa - sb;
                6'h24: r = longint'(a & b);
                6'h25: r = longint'(a | b);
`ifdef ALU_SLT_EN
                6'h27: r = longint'(~(a | b));
                6'h2A: r = (sa < sb) ? 1 : 0;
`endif
                default: r = 0;
            endcase
        end
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                           input logic [1:0] op, input logic [31:0] er, input logic ez);
        vec_t v;
        v.a = a; v.b = b; v.f = f; v.op = op; v.exp_res = er; v.exp_zero = ez;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input logic [1:0] op);
        @(negedge clk);
        A = a; B = b; funct = f; alu_op = op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        A = 32'd10; B = 32'd10; funct = 6'h20; alu_op = 2'b10;

        // Asynchronous reset assertion, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_res_async", alu_res, 32'h0);
        check("reset_zero_async", {31'h0, zero}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_res_held", alu_res, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_add", alu_res, 32'd20);
        check("post_reset_zero", {31'h0, zero}, 32'h0);

        // Mid-operation async clear between edges.
        #2 rst_n = 1'b0;
        #1;
        check("midop_reset_res", alu_res, 32'h0);
        check("midop_reset_zero", {31'h0, zero}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        add_vec(32'd10, 32'd10, 6'h00, 2'b10, 32'h0, 1'b1);
        add_vec(32'd10, 32'd10, 6'h18, 2'b10, 32'd100, 1'b0);
        add_vec(32'd10, 32'd10, 6'h1A, 2'b10, 32'd1, 1'b0);
        add_vec(32'd10, 32'd10, 6'h20, 2'b10, 32'd20, 1'b0);
        add_vec(32'd10, 32'd10, 6'h22, 2'b10, 32'd0, 1'b1);
        add_vec(32'd10, 32'd10, 6'h24, 2'b10, 32'd10, 1'b0);
        add_vec(32'd10, 32'd10, 6'h25, 2'b10, 32'd10, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 6'h00, 2'b00, 32'h0, 1'b1);
        add_vec(32'd5, 32'd7, 6'h00, 2'b01, 32'hFFFF_FFFE, 1'b0);
        add_vec(32'd3, 32'd4, 6'h22, 2'b00, 32'd7, 1'b0);
        add_vec(32'd3, 32'd4, 6'h22, 2'b11, 32'd7, 1'b0);
        add_vec(32'hFFFF_FFF9, 32'd2, 6'h1A, 2'b10, 32'hFFFF_FFFD, 1'b0);
        add_vec(32'd5, 32'd0, 6'h1A, 2'b10, 32'hFFFF_FFFF, 1'b0);
        add_vec(32'h8000_0000, 32'hFFFF_FFFF, 6'h1A, 2'b10, 32'h8000_0000, 1'b0);
        add_vec(32'h0001_0000, 32'h0001_0000, 6'h18, 2'b10, 32'h0, 1'b1);
        add_vec(32'h0000_0001, 32'hFFFF_FFFF, 6'h2A, 2'b10, 32'h0, 1'b1);
`ifdef ALU_SLT_EN
        add_vec(32'hFFFF_FFFF, 32'd1, 6'h2A, 2'b10, 32'h1, 1'b0);
        add_vec(32'h0, 32'h0, 6'h27, 2'b10, 32'hFFFF_FFFF, 1'b0);
`else
        add_vec(32'hFFFF_FFFF, 32'd1, 6'h2A, 2'b10, 32'h0, 1'b1);
        add_vec(32'h0, 32'h0, 6'h27, 2'b10, 32'h0, 1'b1);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].op);
            check($sformatf("vec%0d_res", i), alu_res, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), {31'h0, zero}, {31'h0, vecs[i].exp_zero});
        end

        for (int n = 0; n < 400; n++) begin
            logic [31:0] ra, rb, er;
            logic [5:0]  rf;
            logic [1:0]  rop;
            logic [5:0]  fsel [10];
            fsel = '{6'h18, 6'h1A, 6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h3F};
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = $urandom_range(0, 15) - 8;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            rop = 2'($urandom_range(0, 3));
            rf  = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fsel[$urandom_range(0, 9)];
            er  = model(ra, rb, rf, rop);
            drive(ra, rb, rf, rop);
            check($sformatf("rand%0d_res op=%0d f=%h a=%h b=%h", n, rop, rf, ra, rb), alu_res, er);
            check($sformatf("rand%0d_zero", n), {31'h0, zero}, {31'h0, (er == 32'h0)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
